// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and small-sigma helpers used by the message
// schedule and the round datapath.
package sha256_pkg;

    localparam int unsigned WordW    = 32;
    localparam int unsigned WinDepth = 16;
    localparam int unsigned NumShift = 48;

    // Padding words for a fixed 256-bit message in a single 512-bit block
    localparam logic [31:0] PAD_WORD     = 32'h8000_0000;
    localparam logic [31:0] LEN_WORD_256 = 32'h0000_0100;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule for a fixed 32-byte message: 16-word sliding
// window with a combinational W_t read port.
// Optional macro SHA_MS_CHECK_EN adds a sticky sequencing-error output err.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         shift,
    input  logic [5:0]   t,
    input  logic [255:0] msg_block,
`ifdef SHA_MS_CHECK_EN
    output logic         err,
`endif
    output logic [31:0]  W_t,
    output logic         valid
);

    logic [31:0] w_q [WinDepth];
    logic [31:0] w_d [WinDepth];
    logic        valid_q;
    logic        valid_d;
    logic [31:0] w_next;
    logic        shift_en;

    // Shift is only honoured on a loaded window and loses to init
    assign shift_en = shift && valid_q && !init;

    // Recurrence for the word entering the top of the window
    always_comb begin
        w_next = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];
    end

    // Next-state for the window: reload on init, slide on accepted shift
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < WinDepth; i++) begin
            w_d[i] = w_q[i];
        end
        if (init) begin
            for (int i = 0; i < 8; i++) begin
                w_d[i] = msg_block[255 - 32 * i -: 32];
            end
            w_d[8] = PAD_WORD;
            for (int i = 9; i < 15; i++) begin
                w_d[i] = '0;
            end
            w_d[15] = LEN_WORD_256;
            valid_d = 1'b1;
        end else if (shift_en) begin
            for (int i = 0; i < WinDepth - 1; i++) begin
                w_d[i] = w_q[i + 1];
            end
            w_d[15] = w_next;
        end
    end

    // Window and valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WinDepth; i++) begin
                w_q[i] <= '0;
            end
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < WinDepth; i++) begin
                w_q[i] <= w_d[i];
            end
            valid_q <= valid_d;
        end
    end

    // Rounds 16..63 all read the newest word; earlier rounds index directly
    always_comb begin
        if (t < 6'd16) begin
            W_t = w_q[t[3:0]];
        end else begin
            W_t = w_q[15];
        end
    end

    assign valid = valid_q;

`ifdef SHA_MS_CHECK_EN
    logic [5:0] shift_cnt_q;
    logic [5:0] shift_cnt_d;
    logic       err_q;
    logic       err_d;
    logic       bad_shift;

    assign bad_shift = shift && (!valid_q || (t < 6'd15) ||
                                 (shift_cnt_q >= 6'(NumShift)));

    // Shift counter (saturating) and sticky error, both cleared by init
    always_comb begin
        shift_cnt_d = shift_cnt_q;
        err_d       = err_q;
        if (init) begin
            shift_cnt_d = '0;
            err_d       = 1'b0;
        end else begin
            if (shift_en && (shift_cnt_q != 6'h3f)) begin
                shift_cnt_d = shift_cnt_q + 6'd1;
            end
            if (bad_shift) begin
                err_d = 1'b1;
            end
        end
    end

    // Checker state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            shift_cnt_q <= shift_cnt_d;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed self-checking bench for sha256_msg_schedule.
module tb_sha256_msg_schedule;

    logic         clk;
    logic         rst_n;
    logic         init;
    logic         shift;
    logic [5:0]   t;
    logic [255:0] msg_block;
    logic [31:0]  W_t;
    logic         valid;
`ifdef SHA_MS_CHECK_EN
    logic         err;
`endif

    int total;
    int bad;

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .shift     (shift),
        .t         (t),
        .msg_block (msg_block),
`ifdef SHA_MS_CHECK_EN
        .err       (err),
`endif
        .W_t       (W_t),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference schedule
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    logic [31:0] exp_w [64];

    task automatic build_model(input logic [255:0] m);
        for (int i = 0; i < 8; i++) exp_w[i] = m[255 - 32 * i -: 32];
        exp_w[8] = 32'h8000_0000;
        for (int i = 9; i < 15; i++) exp_w[i] = 32'h0;
        exp_w[15] = 32'h0000_0100;
        for (int i = 16; i < 64; i++) begin
            exp_w[i] = ms1(exp_w[i - 2]) + exp_w[i - 7] + ms0(exp_w[i - 15]) + exp_w[i - 16];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [255:0] m);
        msg_block = m;
        init      = 1'b1;
        tick();
        init      = 1'b0;
    endtask

    task automatic do_shift(input logic [5:0] tv);
        t     = tv;
        shift = 1'b1;
        tick();
        shift = 1'b0;
    endtask

    task automatic chk_w(input string name, input logic [5:0] tv, input logic [31:0] expv);
        t = tv;
        #1;
        total++;
        if (W_t !== expv) begin
            bad++;
            $display("FAIL %s t=%0d W_t=%08h expected=%08h", name, tv, W_t, expv);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b expected=0", valid);
        end
        chk_w("reset_w0", 6'd0, 32'h0);
        chk_w("reset_w15", 6'd15, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_shift_invalid();
        for (int i = 0; i < 3; i++) do_shift(6'd16);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL inv_valid got=%b expected=0", valid);
        end
        chk_w("inv_w0", 6'd0, 32'h0);
        chk_w("inv_w15", 6'd15, 32'h0);
`ifdef SHA_MS_CHECK_EN
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL inv_err got=%b expected=1", err);
        end
        do_init(256'h0);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL inv_err_clear got=%b expected=0", err);
        end
`endif
    endtask

    task automatic test_init_abcd();
        do_init({32'h6162_6364, 224'h0});
        total++;
        if (valid !== 1'b1) begin
            bad++;
            $display("FAIL init_valid got=%b expected=1", valid);
        end
        chk_w("init_w0", 6'd0, 32'h6162_6364);
        chk_w("init_w1", 6'd1, 32'h0);
        chk_w("init_w8", 6'd8, 32'h8000_0000);
        chk_w("init_w9", 6'd9, 32'h0);
        chk_w("init_w15", 6'd15, 32'h0000_0100);
    endtask

    task automatic test_zero_shifts();
        do_init(256'h0);
        t = 6'd15;
        do_shift(6'd15);
        chk_w("zero_w16", 6'd16, 32'h0000_0000);
        do_shift(6'd16);
        chk_w("zero_w17", 6'd17, 32'h00A0_0000);
        do_shift(6'd17);
        chk_w("zero_w18", 6'd18, 32'h0000_0000);
        do_shift(6'd18);
        chk_w("zero_w19", 6'd19, 32'h0000_2844);
    endtask

    task automatic run_full(input string name, input logic [255:0] m);
        build_model(m);
        do_init(m);
        for (int k = 0; k < 64; k++) begin
            chk_w(name, 6'(k), exp_w[k]);
            if (k >= 15 && k <= 62) do_shift(6'(k));
        end
`ifdef SHA_MS_CHECK_EN
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL %s_err got=%b expected=0", name, err);
        end
`endif
    endtask

    task automatic test_full_random();
        logic [255:0] m;
        for (int i = 0; i < 8; i++) m[32 * i +: 32] = $urandom;
        run_full("full_rand", m);
    endtask

    task automatic test_full_ascii();
        // "abcdefghijklmnopqrstuvwxyz012345"
        run_full("full_ascii", 256'h6162636465666768696a6b6c6d6e6f707172737475767778797a303132333435);
    endtask

    task automatic test_init_shift_together();
        logic [255:0] m1;
        logic [255:0] m2;
        m1 = {8{32'hdead_beef}};
        m2 = 256'h0011223344556677_8899aabbccddeeff_0123456789abcdef_fedcba9876543210;
        do_init(m1);
        for (int i = 0; i < 10; i++) do_shift(6'(15 + i));
        msg_block = m2;
        t     = 6'd25;
        init  = 1'b1;
        shift = 1'b1;
        tick();
        init  = 1'b0;
        shift = 1'b0;
        chk_w("both_w0", 6'd0, 32'h0011_2233);
        chk_w("both_w7", 6'd7, 32'h7654_3210);
        chk_w("both_w14", 6'd14, 32'h0);
        chk_w("both_w15", 6'd15, 32'h0000_0100);
    endtask

    task automatic test_reset_midrun();
        do_init({8{32'h1234_5678}});
        for (int i = 0; i < 20; i++) do_shift(6'(15 + i));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_valid got=%b expected=0", valid);
        end
        chk_w("mid_rst_w35", 6'd35, 32'h0);
        chk_w("mid_rst_w0", 6'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_init({32'hcafe_f00d, 224'h0});
        chk_w("mid_rst_reload_w0", 6'd0, 32'hcafe_f00d);
        chk_w("mid_rst_reload_w15", 6'd15, 32'h0000_0100);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b1;
        init      = 1'b0;
        shift     = 1'b0;
        t         = 6'd0;
        msg_block = '0;
        test_reset();
        test_shift_invalid();
        test_init_abcd();
        test_zero_shifts();
        test_full_random();
        test_full_ascii();
        test_init_shift_together();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
